sun_pll_lock: RTL and testbench
===============================

SUN_PLL_LOCK -- requirements
Module: sun_pll_lock

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SETTLE_CYC, 256: CK_REF cycles held in PWRUP before lock acquisition starts.
- LOCK_CNT, 64: consecutive synchronized lock-good cycles required to declare lock.
- UNLOCK_CNT, 4: consecutive lock-bad cycles while LOCKED that declare loss of lock.
- TIMEOUT_CYC, 4096: maximum ACQ duration before FAIL.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset; ports (name, direction, width, meaning):
- CK_REF, in, 1: reference clock; sole clock.
- RST_N, in, 1: asynchronous active-low reset.
- EN, in, 1: asynchronous PLL enable request.
- LOCK_DET, in, 1: asynchronous raw lock indicator from PFD pulse-width detector.
- PWRUP_1V8, out, 1: PLL power-up drive to CP, ROSC and DIVN.
- CK_EN, out, 1: gate enable for PLL output clock consumers.
- LOCKED, out, 1: lock status.
- LOST, out, 1: sticky lock-lost flag.
- TIMEOUT, out, 1: sticky acquisition-timeout flag.
- STATE, out, 3: current FSM state encoding.

Function
REQ-003 EN and LOCK_DET SHALL each pass through a 2-flop synchronizer on CK_REF (en_s, lock_s) before any use.
REQ-004 FSM states and encodings SHALL be IDLE=0, PWRUP=1, ACQ=2, LOCKED=3, FAIL=4; all outputs SHALL be registered.
REQ-005 IDLE: when en_s=1, the FSM SHALL go to PWRUP; EN rising to PWRUP_1V8=1 SHALL take exactly 3 CK_REF edges.
REQ-006 PWRUP: PWRUP_1V8=1; the settle counter SHALL count SETTLE_CYC cycles, then the FSM SHALL go to ACQ. lock_s SHALL be ignored in PWRUP.
REQ-007 ACQ: the lock counter SHALL increment on lock_s=1 and clear to 0 on lock_s=0; reaching LOCK_CNT SHALL move to LOCKED. The timeout counter SHALL increment every ACQ cycle; reaching TIMEOUT_CYC SHALL move to FAIL and set TIMEOUT.
REQ-008 If lock and timeout thresholds are reached in the same cycle, lock SHALL win.
REQ-009 LOCKED: LOCKED=1 and CK_EN=1. UNLOCK_CNT consecutive lock_s=0 cycles SHALL return to ACQ, set LOST, and clear LOCKED and CK_EN on the transition edge. Any lock_s=1 SHALL clear the unlock counter.
REQ-010 On ACQ re-entry, the lock and timeout counters SHALL restart from 0.
REQ-011 FAIL: PWRUP_1V8=0, CK_EN=0, LOCKED=0; the FSM SHALL hold until en_s=0 (REQ-012).
REQ-012 en_s=0 in any state SHALL move to IDLE on the next edge and clear PWRUP_1V8, CK_EN and LOCKED. This SHALL take priority over all other transitions.
REQ-013 LOST and TIMEOUT SHALL be sticky and clear only on IDLE-to-PWRUP entry or on reset.
REQ-014 Counters SHALL be sized from their parameter with $clog2 and SHALL saturate, never wrap. Parameters below 1 are illegal and SHALL be flagged by an elaboration-time check.

Reset
REQ-015 RST_N low SHALL asynchronously force:
- STATE=IDLE, PWRUP_1V8=0, CK_EN=0, LOCKED=0, LOST=0, TIMEOUT=0;
- all counters and synchronizer flops to 0.
REQ-016 Reset deassertion SHALL be synchronous to CK_REF through the flop structure. Reset mid-operation SHALL abandon any state with no residual flag.

Configuration
REQ-017 With SUN_PLL_LOCK_RETRY_EN defined, FAIL SHALL wait 16 cycles with PWRUP_1V8=0, then re-enter PWRUP, for at most 3 retries per enable. The retry counter SHALL clear in IDLE. After the third failure, FAIL SHALL hold.
REQ-018 Without SUN_PLL_LOCK_RETRY_EN, FAIL SHALL hold per REQ-011 and no retry logic SHALL be synthesized.

Verification
REQ-019 The bench SHALL cover these directed scenarios (SETTLE_CYC=8, LOCK_CNT=4, UNLOCK_CNT=2, TIMEOUT_CYC=32):
- Nominal lock: EN=1, LOCK_DET=1 constantly -> PWRUP_1V8=1 at edge 3, STATE=ACQ at edge 11, LOCKED=1 and CK_EN=1 at edge 15 (±0 cycles, sync delay included).
- Glitchy acquisition: LOCK_DET=1 for 3 cycles, 0 for 1 cycle, then 1 -> counter clears; LOCKED asserts only 4 synchronized good cycles after the gap.
- Loss of lock: in LOCKED, LOCK_DET=0 for 1 cycle -> stays LOCKED; LOCK_DET=0 for 2 cycles -> STATE=ACQ, LOST=1, CK_EN=0; later relock -> LOCKED=1 with LOST still 1.
- Timeout: LOCK_DET=0 -> TIMEOUT=1, STATE=FAIL after 32 ACQ cycles; with RETRY_EN, PWRUP re-entered 16 cycles later, 3 times, then FAIL holds.
- Disable and reset mid-operation: EN=0 during ACQ -> IDLE and PWRUP_1V8=0 within 3 edges; RST_N pulse during LOCKED -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sun_pll_lock.sv
// rtl/sun_pll_lock.sv - PLL power-up, lock acquisition and loss-of-lock supervisor on CK_REF.
// Optional FAIL auto-retry is built only when SUN_PLL_LOCK_RETRY_EN is defined.
module sun_pll_lock #(
  parameter int SETTLE_CYC  = 256,
  parameter int LOCK_CNT    = 64,
  parameter int UNLOCK_CNT  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       CK_REF,
  input  logic       RST_N,
  input  logic       EN,
  input  logic       LOCK_DET,
  output logic       PWRUP_1V8,
  output logic       CK_EN,
  output logic       LOCKED,
  output logic       LOST,
  output logic       TIMEOUT,
  output logic [2:0] STATE
);

  if (SETTLE_CYC < 1 || LOCK_CNT < 1 || UNLOCK_CNT < 1 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("sun_pll_lock: all cycle-count parameters must be >= 1");
  end

  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
  localparam logic [LW-1:0] LOCK_LAST   = LW'(LOCK_CNT - 1);
  localparam logic [UW-1:0] UNL_LAST    = UW'(UNLOCK_CNT - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PWRUP  = 3'd1,
    S_ACQ    = 3'd2,
    S_LOCKED = 3'd3,
    S_FAIL   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic          en_meta_q, en_s_q, lock_meta_q, lock_s_q;
  logic [SW-1:0] settle_q, settle_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [UW-1:0] unl_q, unl_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          pwrup_q, pwrup_d, ck_en_q, ck_en_d, locked_q, locked_d;
  logic          lost_q, lost_d, timeout_q, timeout_d;
  logic          settle_done, lock_hit, tmo_hit, unlock_hit;

  assign settle_done = (settle_q == SETTLE_LAST);
  assign lock_hit    = lock_s_q && (lock_q == LOCK_LAST);
  assign tmo_hit     = (tmo_q == TMO_LAST);
  assign unlock_hit  = !lock_s_q && (unl_q == UNL_LAST);

`ifdef SUN_PLL_LOCK_RETRY_EN
  logic [3:0] fwait_q, fwait_d;
  logic [1:0] retry_q, retry_d;
  logic       retry_go;

  assign retry_go = (fwait_q == 4'd15) && (retry_q != 2'd3);

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      fwait_q <= '0;
      retry_q <= '0;
    end else begin
      fwait_q <= fwait_d;
      retry_q <= retry_d;
    end
  end

  always_comb begin
    fwait_d = '0;
    retry_d = retry_q;
    if (state_q == S_FAIL && state_d == S_FAIL && fwait_q != 4'hf) fwait_d = fwait_q + 4'd1;
    if (state_q == S_FAIL && state_d == S_PWRUP) retry_d = retry_q + 2'd1;
    if (state_q == S_IDLE) retry_d = '0;
  end
`endif

  // EN and LOCK_DET are asynchronous to CK_REF
  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      en_meta_q   <= 1'b0;
      en_s_q      <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      en_meta_q   <= EN;
      en_s_q      <= en_meta_q;
      lock_meta_q <= LOCK_DET;
      lock_s_q    <= lock_meta_q;
    end
  end

  always_ff @(posedge CK_REF or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      settle_q  <= '0;
      lock_q    <= '0;
      unl_q     <= '0;
      tmo_q     <= '0;
      pwrup_q   <= 1'b0;
      ck_en_q   <= 1'b0;
      locked_q  <= 1'b0;
      lost_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      lock_q    <= lock_d;
      unl_q     <= unl_d;
      tmo_q     <= tmo_d;
      pwrup_q   <= pwrup_d;
      ck_en_q   <= ck_en_d;
      locked_q  <= locked_d;
      lost_q    <= lost_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en_s_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_PWRUP;
        S_PWRUP:  if (settle_done) state_d = S_ACQ;
        S_ACQ: begin
          // lock beats timeout when both land on the same cycle
          if (lock_hit)     state_d = S_LOCKED;
          else if (tmo_hit) state_d = S_FAIL;
        end
        S_LOCKED: if (unlock_hit) state_d = S_ACQ;
`ifdef SUN_PLL_LOCK_RETRY_EN
        S_FAIL:   if (retry_go) state_d = S_PWRUP;
`else
        S_FAIL:   state_d = S_FAIL;
`endif
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Counters restart whenever their state is entered; outputs are registered from state_d
  always_comb begin
    settle_d  = '0;
    lock_d    = '0;
    unl_d     = '0;
    tmo_d     = '0;
    lost_d    = lost_q;
    timeout_d = timeout_q;
    if (state_q == S_PWRUP && state_d == S_PWRUP)
      settle_d = (settle_q == '1) ? settle_q : settle_q + 1'b1;
    if (state_q == S_ACQ && state_d == S_ACQ) begin
      tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + 1'b1;
      if (lock_s_q) lock_d = (lock_q == '1) ? lock_q : lock_q + 1'b1;
    end
    if (state_q == S_LOCKED && state_d == S_LOCKED && !lock_s_q)
      unl_d = (unl_q == '1) ? unl_q : unl_q + 1'b1;
    if (state_q == S_LOCKED && state_d == S_ACQ) lost_d = 1'b1;
    if (state_q == S_ACQ && state_d == S_FAIL) timeout_d = 1'b1;
    if (state_q == S_IDLE && state_d == S_PWRUP) begin
      lost_d    = 1'b0;
      timeout_d = 1'b0;
    end
    pwrup_d  = (state_d == S_PWRUP) || (state_d == S_ACQ) || (state_d == S_LOCKED);
    ck_en_d  = (state_d == S_LOCKED);
    locked_d = (state_d == S_LOCKED);
  end

  assign PWRUP_1V8 = pwrup_q;
  assign CK_EN     = ck_en_q;
  assign LOCKED    = locked_q;
  assign LOST      = lost_q;
  assign TIMEOUT   = timeout_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_sun_pll_lock.sv
// tb/tb_sun_pll_lock.sv - directed self-checking bench for sun_pll_lock.
module tb_sun_pll_lock;

  logic       CK_REF = 1'b0;
  logic       RST_N, EN, LOCK_DET;
  logic       PWRUP_1V8, CK_EN, LOCKED, LOST, TIMEOUT;
  logic [2:0] STATE;
  int         checks = 0;
  int         errors = 0;

  sun_pll_lock #(
    .SETTLE_CYC (8),
    .LOCK_CNT   (4),
    .UNLOCK_CNT (2),
    .TIMEOUT_CYC(32)
  ) dut (
    .CK_REF   (CK_REF),
    .RST_N    (RST_N),
    .EN       (EN),
    .LOCK_DET (LOCK_DET),
    .PWRUP_1V8(PWRUP_1V8),
    .CK_EN    (CK_EN),
    .LOCKED   (LOCKED),
    .LOST     (LOST),
    .TIMEOUT  (TIMEOUT),
    .STATE    (STATE)
  );

  always #5 CK_REF = ~CK_REF;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CK_REF);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b0; LOCK_DET = 1'b0;
    tick(2);
    check("rst_state", 32'(STATE), 0);
    check("rst_pwrup", 32'(PWRUP_1V8), 0);
    check("rst_locked", 32'(LOCKED), 0);
    check("rst_flags", {30'd0, LOST, TIMEOUT}, 0);
    RST_N = 1'b1;

    // nominal lock: edge numbers counted from EN rising
    EN = 1'b1; LOCK_DET = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick(1);
      if (k == 2)  check("nom_pwrup_e2", 32'(PWRUP_1V8), 0);
      if (k == 3)  check("nom_pwrup_e3", 32'(PWRUP_1V8), 1);
      if (k == 10) check("nom_state_e10", 32'(STATE), 1);
      if (k == 11) check("nom_state_e11", 32'(STATE), 2);
      if (k == 14) check("nom_locked_e14", 32'(LOCKED), 0);
      if (k == 15) begin
        check("nom_state_e15", 32'(STATE), 3);
        check("nom_locked_e15", {30'd0, LOCKED, CK_EN}, 3);
      end
    end

    // single bad cycle in LOCKED is tolerated
    LOCK_DET = 1'b0; tick(1); LOCK_DET = 1'b1;
    tick(5);
    check("lol1_state", 32'(STATE), 3);
    check("lol1_lost", 32'(LOST), 0);

    // two bad cycles drop lock
    LOCK_DET = 1'b0; tick(2); LOCK_DET = 1'b1;
    tick(1);
    check("lol2_still_locked", 32'(STATE), 3);
    tick(1);
    check("lol2_state", 32'(STATE), 2);
    check("lol2_outs", {29'd0, LOST, CK_EN, LOCKED}, 3'b100);
    tick(3);
    check("relock_e3", 32'(STATE), 2);
    tick(1);
    check("relock_state", 32'(STATE), 3);
    check("relock_lost_sticky", {30'd0, LOCKED, LOST}, 3);

    // disable from LOCKED; LOST stays sticky in IDLE
    EN = 1'b0;
    tick(2);
    check("dis_e2", 32'(STATE), 3);
    tick(1);
    check("dis_e3", 32'(STATE), 0);
    check("dis_outs", {29'd0, PWRUP_1V8, CK_EN, LOCKED}, 0);
    check("dis_lost", 32'(LOST), 1);

    // glitchy acquisition: one bad synchronized cycle at the 4th ACQ cycle
    EN = 1'b1; LOCK_DET = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      tick(1);
      if (k == 12) LOCK_DET = 1'b0;
      if (k == 13) LOCK_DET = 1'b1;
      if (k == 3)  check("gl_lost_cleared", 32'(LOST), 0);
      if (k == 11) check("gl_acq", 32'(STATE), 2);
      if (k == 15) check("gl_not_locked_e15", 32'(STATE), 2);
      if (k == 18) check("gl_not_locked_e18", 32'(LOCKED), 0);
      if (k == 19) check("gl_locked_e19", {29'd0, STATE}, 3);
    end

    EN = 1'b0;
    tick(3);
    check("gl_dis", 32'(STATE), 0);

    // timeout: lock never arrives
    EN = 1'b1; LOCK_DET = 1'b0;
    for (int k = 1; k <= 43; k++) begin
      tick(1);
      if (k == 11) check("to_acq", 32'(STATE), 2);
      if (k == 42) check("to_e42", {29'd0, STATE}, {28'd0, TIMEOUT, 3'd2} & 32'h7);
      if (k == 42) check("to_flag_e42", 32'(TIMEOUT), 0);
      if (k == 43) begin
        check("to_fail", 32'(STATE), 4);
        check("to_flag", {30'd0, TIMEOUT, PWRUP_1V8}, 2'b10);
      end
    end
`ifdef SUN_PLL_LOCK_RETRY_EN
    for (int k = 44; k <= 300; k++) begin
      tick(1);
      if (k == 58)  check("rt_wait", {29'd0, STATE}, 4);
      if (k == 59)  check("rt1_pwrup", {28'd0, PWRUP_1V8, STATE}, {28'd1, 3'd1});
      if (k == 59)  check("rt1_timeout_sticky", 32'(TIMEOUT), 1);
      if (k == 99)  check("rt1_fail", 32'(STATE), 4);
      if (k == 115) check("rt2_pwrup", 32'(STATE), 1);
      if (k == 155) check("rt2_fail", 32'(STATE), 4);
      if (k == 171) check("rt3_pwrup", 32'(STATE), 1);
      if (k == 211) check("rt3_fail", 32'(STATE), 4);
      if (k == 300) check("rt_hold", {28'd0, PWRUP_1V8, STATE}, 4);
    end
`else
    tick(60);
    check("fail_hold", {28'd0, PWRUP_1V8, STATE}, 4);
    check("fail_hold_flag", 32'(TIMEOUT), 1);
`endif

    EN = 1'b0;
    tick(3);
    check("fail_dis", 32'(STATE), 0);

    // disable during ACQ; TIMEOUT cleared on re-entry to PWRUP
    EN = 1'b1; LOCK_DET = 1'b0;
    tick(20);
    check("dacq_state", 32'(STATE), 2);
    check("dacq_to_cleared", 32'(TIMEOUT), 0);
    EN = 1'b0;
    tick(2);
    check("dacq_e2", 32'(STATE), 2);
    tick(1);
    check("dacq_idle", {28'd0, PWRUP_1V8, STATE}, 0);

    // async reset while LOCKED (after a loss so LOST is set)
    EN = 1'b1; LOCK_DET = 1'b1;
    tick(15);
    check("rs_locked", 32'(LOCKED), 1);
    LOCK_DET = 1'b0; tick(2); LOCK_DET = 1'b1;
    tick(2);
    check("rs_lost", 32'(LOST), 1);
    tick(4);
    check("rs_relocked", 32'(STATE), 3);
    #3;
    RST_N = 1'b0;
    #1;
    check("rs_async_state", 32'(STATE), 0);
    check("rs_async_outs", {27'd0, PWRUP_1V8, CK_EN, LOCKED, LOST, TIMEOUT}, 0);
    #2;
    RST_N = 1'b1;
    tick(2);
    check("rs_resync_e2", 32'(PWRUP_1V8), 0);
    tick(1);
    check("rs_resync_e3", {28'd0, PWRUP_1V8, STATE}, {28'd1, 3'd1});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
